// File: rtl/uart_pkg.sv
// Shared UART constants: baud_set codes, receiver state encoding, oversample points, divisor helper.
// Latency: none (declarations only).
// Backpressure: none.
// Build option: UART_RX_PARITY_EN adds the PARITY state for 8E1 frames.
package uart_pkg;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SAMPLE_LO  = 7;
    localparam int unsigned SAMPLE_HI  = 9;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    // Clocks per oversample tick, truncated; codes above 115200 fall back to 115200.
    // Each branch divides constants only, so this folds to a small lookup in hardware.
    function automatic int unsigned div_of(input int unsigned clk_freq, input logic [2:0] baud_set);
        case (baud_set)
            BAUD_9600:  return clk_freq / (OVERSAMPLE * 32'd9600);
            BAUD_19200: return clk_freq / (OVERSAMPLE * 32'd19200);
            BAUD_38400: return clk_freq / (OVERSAMPLE * 32'd38400);
            BAUD_57600: return clk_freq / (OVERSAMPLE * 32'd57600);
            default:    return clk_freq / (OVERSAMPLE * 32'd115200);
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Baud tick generator: one-cycle tick every div_of(CLK_FREQ, baud_set) clocks.
// Latency: first tick DIV clocks after clr drops; then one tick every DIV clocks.
// Backpressure: none; clr holds the divider at zero with tick low.
module uart_baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [2:0] baud_set,
    output logic       tick
);

    localparam int CW = 16;

    logic [CW-1:0] cnt;
    logic [CW-1:0] div_last;

    // Terminal count of the divider for the selected rate.
    always_comb div_last = CW'(div_of(CLK_FREQ, baud_set) - 32'd1);

    // Count 0..DIV-1 and raise tick for one cycle on each wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == div_last) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 8N1 (8E1 with UART_RX_PARITY_EN), 16x oversampling, 3-sample majority per bit.
// Latency: rx_done about 9.5 bit times after the start edge (10.5 with parity), 2-cycle sync included.
// Backpressure: none; rx_done is a one-cycle strobe and data_byte/frame_err/parity_err hold until the next one.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_set,
    input  logic       rs232_rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       uart_state,
    output logic       frame_err,
    output logic       parity_err
);

    localparam logic [3:0] TICK_LO   = 4'(SAMPLE_LO);
    localparam logic [3:0] TICK_MID  = 4'(SAMPLE_LO + 1);
    localparam logic [3:0] TICK_HI   = 4'(SAMPLE_HI);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    state_t     state, next_state;
    logic       rx_s1, rx_s2, rx_prev;
    logic       fall;
    logic [2:0] baud_q;
    logic       tick, tick_clr;
    logic [3:0] slot_cnt;
    logic [2:0] bit_cnt;
    logic       smp_lo, smp_mid, maj;
    logic [7:0] shreg;
    logic       start_det, shift_en, bit_inc, done_en;
`ifdef UART_RX_PARITY_EN
    logic       par_en, par_bit;
`endif

    // Idle-high synchronizer plus one history stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rs232_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // A line stuck low never produces another edge, so a break cannot retrigger.
    assign fall       = rx_prev & ~rx_s2;
    // Majority of the two stored samples and the live sample taken at TICK_HI.
    assign maj        = (smp_lo & smp_mid) | (smp_lo & rx_s2) | (smp_mid & rx_s2);
    assign uart_state = (state != IDLE);
    assign tick_clr   = (state == IDLE);

    uart_baud_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .clr      (tick_clr),
        .baud_set (baud_q),
        .tick     (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and datapath strobes; STOP exits at TICK_HI so a back-to-back start edge is not missed.
    always_comb begin
        next_state = state;
        start_det  = 1'b0;
        shift_en   = 1'b0;
        bit_inc    = 1'b0;
        done_en    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (fall) begin
                    start_det  = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                if (tick) begin
                    if (slot_cnt == TICK_HI && maj)  next_state = IDLE;
                    else if (slot_cnt == TICK_LAST)  next_state = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (slot_cnt == TICK_HI) shift_en = 1'b1;
                    if (slot_cnt == TICK_LAST) begin
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            next_state = PARITY;
`else
                            next_state = STOP;
`endif
                        end else begin
                            bit_inc = 1'b1;
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (slot_cnt == TICK_HI)   par_en     = 1'b1;
                    if (slot_cnt == TICK_LAST) next_state = STOP;
                end
            end
`endif
            STOP: begin
                if (tick && slot_cnt == TICK_HI) begin
                    done_en    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Baud latch, slot/bit counters, centre samples and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q   <= BAUD_9600;
            slot_cnt <= '0;
            bit_cnt  <= '0;
            smp_lo   <= 1'b0;
            smp_mid  <= 1'b0;
            shreg    <= '0;
        end else begin
            if (start_det) baud_q <= baud_set;
            if (state == IDLE) begin
                slot_cnt <= '0;
                bit_cnt  <= '0;
            end else if (tick) begin
                slot_cnt <= slot_cnt + 1'b1;
                if (slot_cnt == TICK_LO)  smp_lo  <= rx_s2;
                if (slot_cnt == TICK_MID) smp_mid <= rx_s2;
                if (bit_inc)              bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en) shreg <= {maj, shreg[7:1]};
        end
    end

    // Publish the byte and stop-bit status only when the frame closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_byte <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done <= done_en;
            if (done_en) begin
                data_byte <= shreg;
                frame_err <= ~maj;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Capture the parity slot and check even parity when the frame closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_en)  par_bit    <= maj;
            if (done_en) parity_err <= (^shreg) ^ par_bit;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Testbench for uart_byte_rx: behavioural line model drives frames, a scoreboard checks every rx_done.
// The clock is a baud-rate crystal frequency so every rate divides exactly and the run stays short.
// Honours UART_RX_PARITY_EN by sending 8E1 frames.
module tb_uart_byte_rx;

    localparam int CLK_FREQ = 7_372_800;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [2:0] baud_set = 3'd4;
    logic       rs232_rx = 1'b1;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       uart_state;
    logic       frame_err;
    logic       parity_err;

    uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_set   (baud_set),
        .rs232_rx   (rs232_rx),
        .data_byte  (data_byte),
        .rx_done    (rx_done),
        .uart_state (uart_state),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        int         start_cyc;
        int         bit_clks;
        bit         lat_chk;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_done   = 0;
    int         n_pushed = 0;
    int         cyc      = 0;
    int         lat, lat_lo, lat_hi;
    logic [7:0] last_data = 8'h00;
    logic [7:0] pat [3] = '{8'h00, 8'hFF, 8'h3C};
    bit         flip_mid;
    int         b;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bit_clks_of(input int bs);
        case (bs)
            0:       return CLK_FREQ / 9600;
            1:       return CLK_FREQ / 19200;
            2:       return CLK_FREQ / 38400;
            3:       return CLK_FREQ / 57600;
            default: return CLK_FREQ / 115200;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting now; caller is always 1 time unit past a rising edge.
    task automatic send_frame(input logic [7:0] d, input int bit_clks, input bit stop_val,
                              input bit par_flip, input bit push, input bit lat_chk);
        exp_t e;
        rs232_rx = 1'b0;
        if (push) begin
            e.data      = d;
            e.ferr      = ~stop_val;
            e.perr      = par_flip;
            e.start_cyc = cyc;
            e.bit_clks  = bit_clks;
            e.lat_chk   = lat_chk;
            sb_q.push_back(e);
            n_pushed++;
            last_data = d;
        end
        wait_clks(bit_clks);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = d[i];
            wait_clks(bit_clks);
        end
`ifdef UART_RX_PARITY_EN
        rs232_rx = (^d) ^ par_flip;
        wait_clks(bit_clks);
`endif
        rs232_rx = stop_val;
        wait_clks(bit_clks);
    endtask

    // Monitor: every rx_done pops one expectation; a pulse with nothing queued is a failure.
    always @(negedge clk) begin
        if (rx_done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rx_done: got pulse with data_byte 0x%0h, want no pulse", data_byte);
            end else begin
                mon_e = sb_q.pop_front();
                check("data_byte", {24'd0, data_byte}, {24'd0, mon_e.data});
                check("frame_err", {31'd0, frame_err}, {31'd0, mon_e.ferr});
                check("parity_err", {31'd0, parity_err}, {31'd0, mon_e.perr});
                if (mon_e.lat_chk) begin
                    lat    = cyc - mon_e.start_cyc;
                    lat_lo = ((20 * FRAME_BITS - 15) * mon_e.bit_clks) / 20;
                    lat_hi = ((20 * FRAME_BITS - 3) * mon_e.bit_clks) / 20;
                    n_checks++;
                    if (lat >= lat_lo && lat <= lat_hi) n_pass++;
                    else $display("FAIL rx_done_latency: got %0d clk after start edge, want %0d..%0d", lat, lat_lo, lat_hi);
                end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got no end of stimulus after 95000 cycles, want completion");
        $fatal(1);
    end

    initial begin
`ifdef UART_RX_PARITY_EN
        flip_mid = 1'b1;
`else
        flip_mid = 1'b0;
`endif
        wait_clks(5);
        check("reset_data_byte", {24'd0, data_byte}, 32'h00);
        check("reset_rx_done", {31'd0, rx_done}, 32'h0);
        check("reset_uart_state", {31'd0, uart_state}, 32'h0);
        check("reset_frame_err", {31'd0, frame_err}, 32'h0);
        check("reset_parity_err", {31'd0, parity_err}, 32'h0);
        rst = 1'b0;
        wait_clks(5);

        // Two bytes at 115200, start edges 5000 clocks apart.
        baud_set = 3'd4;
        b = bit_clks_of(4);
        send_frame(8'hAA, b, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_clks(5000 - FRAME_BITS * b);
        send_frame(8'h55, b, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_clks(b);

        // Every rate with three patterns, then an out-of-range code that must act as 115200.
        for (int bs = 0; bs < 5; bs++) begin
            baud_set = 3'(bs);
            b = bit_clks_of(bs);
            for (int k = 0; k < 3; k++) begin
                send_frame(pat[k], b, 1'b1, 1'b0, 1'b1, 1'b1);
                wait_clks(b);
                check("idle_between_frames", {31'd0, uart_state}, 32'h0);
            end
        end
        baud_set = 3'd7;
        b = bit_clks_of(4);
        send_frame(8'hA5, b, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_clks(b);

        // 40-clock low glitch at 9600: false start, nothing received.
        baud_set = 3'd0;
        wait_clks(100);
        rs232_rx = 1'b0;
        wait_clks(10);
        check("glitch_state_high", {31'd0, uart_state}, 32'h1);
        wait_clks(30);
        rs232_rx = 1'b1;
        wait_clks(bit_clks_of(0));
        check("glitch_state_low", {31'd0, uart_state}, 32'h0);
        check("glitch_data_hold", {24'd0, data_byte}, {24'd0, last_data});

        // Stop bit low, flag holds, then a clean frame clears it.
        baud_set = 3'd4;
        b = bit_clks_of(4);
        send_frame(8'h96, b, 1'b0, 1'b0, 1'b1, 1'b1);
        rs232_rx = 1'b1;
        wait_clks(2 * b);
        check("frame_err_hold", {31'd0, frame_err}, 32'h1);
        send_frame(8'h21, b, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_clks(b);

        // Break: line low for several frame times gives one errored frame and no retrigger.
        send_frame(8'h00, b, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_clks(3 * FRAME_BITS * b);
        check("break_no_retrigger", {31'd0, uart_state}, 32'h0);
        rs232_rx = 1'b1;
        wait_clks(2 * b);

        // Reset during data bit 4 of 0x5A, held until the line is idle again.
        fork
            send_frame(8'h5A, b, 1'b1, 1'b0, 1'b0, 1'b0);
            begin
                wait_clks(5 * b + b / 2);
                rst = 1'b1;
                wait_clks(3);
                check("rst_mid_uart_state", {31'd0, uart_state}, 32'h0);
                check("rst_mid_data_byte", {24'd0, data_byte}, 32'h00);
                check("rst_mid_frame_err", {31'd0, frame_err}, 32'h0);
            end
        join
        wait_clks(2 * b);
        rst = 1'b0;
        wait_clks(5);
        send_frame(8'hC3, b, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_clks(b);

        // Back-to-back frames with the line 2% slow, then 2% fast; middle parity flipped in 8E1.
        baud_set = 3'd2;
        b = bit_clks_of(2);
        send_frame(8'h12, (b * 102 + 50) / 100, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(8'h34, (b * 102 + 50) / 100, 1'b1, flip_mid, 1'b1, 1'b0);
        send_frame(8'h56, (b * 102 + 50) / 100, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_clks(b);
        send_frame(8'h12, (b * 98 + 50) / 100, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(8'h34, (b * 98 + 50) / 100, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_clks(2 * b);

        for (int i = 0; i < 4000 && sb_q.size() != 0; i++) wait_clks(1);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        check("rx_done_count", n_done, n_pushed);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
